bcd_conv_arb: RTL and testbench

BCD_CONV_ARB -- requirements
Module: bcd_conv_arb

---
 rtl/bcd_conv_arb_pkg.sv | 22 ++
 rtl/bcd_conv_arb_digit_adj.sv | 12 +
 rtl/bcd_conv_arb.sv | 154 +++++++++++++++
 tb/tb_bcd_conv_arb.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_arb_pkg.sv
// Shared encodings and constants for the two-requester binary-to-BCD converter.
package bcd_conv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 12;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  // Round-robin pick: on a tie the requester not granted last wins,
  // otherwise whichever one is asking.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

endpackage

// File: rtl/bcd_conv_arb_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift
// so that it carries correctly into the next decimal place.
module bcd_digit_adj
  import bcd_conv_arb_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'(ADJ_THRESH)) ? d_i + 4'(ADJ_ADD) : d_i;

endmodule

// File: rtl/bcd_conv_arb.sv
// Two requesters share one shift-and-add-3 binary-to-BCD converter.
// IDLE grants round-robin, SHIFT runs WIDTH+1 steps, HOLD presents the result
// until the consumer takes it.
module bcd_conv_arb
  import bcd_conv_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH:0]   req0_bin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH:0]   req1_bin,
  output logic             req1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BCD_W-1:0] out_bcd,
  output logic             out_id,
  output logic             busy
);

  localparam int OPW  = WIDTH + 1;
  localparam int CNTW = $clog2(OPW + 1);

  state_e state_q, state_d;

  logic [OPW-1:0]   op_q, op_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             out_valid_q, out_valid_d;
  logic [BCD_W-1:0] out_bcd_q, out_bcd_d;
  logic             out_id_q, out_id_d;
  logic             busy_q, busy_d;

  logic grant;
  logic idle_vld;

  // Per-digit correction of the accumulator, one adjuster per BCD digit.
  logic [BCD_DIGITS-1:0][3:0] dig_in, dig_adj;
  logic [BCD_W-1:0]           adj_flat;
  logic [BCD_W+OPW-1:0]       sh;

  assign dig_in = bcd_q;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .d_i(dig_in[g]),
      .d_o(dig_adj[g])
    );
  end

  assign adj_flat = dig_adj;
  // Adjusted digits and operand shift as one register pair; operand MSB
  // falls into bcd[0].
  assign sh = {adj_flat, op_q} << 1;

  assign grant    = rr_pick(req0_valid, req1_valid, last_q);
  assign idle_vld = (state_q == ST_IDLE) && (req0_valid || req1_valid);

  // Ready is the only combinational output; held low while reset is asserted.
  assign req0_ready = rst_n & idle_vld & ~grant;
  assign req1_ready = rst_n & idle_vld &  grant;

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;

  // Next-state and datapath updates for the IDLE/SHIFT/HOLD sequence.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_id_d    = out_id_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_vld) begin
          state_d = ST_SHIFT;
          op_d    = grant ? req1_bin : req0_bin;
          id_d    = grant;
          last_d  = grant;
          bcd_d   = '0;
          cnt_d   = CNTW'(OPW);
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        bcd_d = sh[BCD_W+OPW-1:OPW];
        op_d  = sh[OPW-1:0];
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
          out_bcd_d   = sh[BCD_W+OPW-1:OPW];
          out_id_d    = id_q;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and registered outputs; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      op_q        <= op_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_id_q    <= out_id_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Directed bench for bcd_conv_arb: reset, operand limits, arbitration,
// backpressure, reset mid-conversion and a full operand sweep.
module tb_bcd_conv_arb;

  localparam int WIDTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [WIDTH:0] req0_bin, req1_bin;
  logic          req0_ready, req1_ready;
  logic          out_valid, out_ready;
  logic [11:0]   out_bcd;
  logic          out_id, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_conv_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_bin(req0_bin), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bin(req1_bin), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_id(out_id), .busy(busy)
  );

  function automatic logic [11:0] dec_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Counts edges until out_valid shows up, capped so the bench cannot hang.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (out_valid !== 1'b1 && lat < 30);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    n_cmp++;
    if ({out_valid, out_id, busy, req0_ready, req1_ready, out_bcd} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b id=%b busy=%b r0=%b r1=%b bcd=%h want all zero",
               out_valid, out_id, busy, req0_ready, req1_ready, out_bcd);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_limits();
    logic [WIDTH:0] vals[3];
    logic [11:0]    exps[3];
    int lat;
    vals = '{9'd255, 9'd0, 9'd511};
    exps = '{12'h255, 12'h000, 12'h511};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      req0_valid = 1'b1; req0_bin = vals[i];
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        n_err++; $display("FAIL limit_ready[%0d]: got %b%b want 10", i, req0_ready, req1_ready);
      end
      @(posedge clk); #2;
      req0_valid = 1'b0; req0_bin = '0;
      #1;
      n_cmp++;
      if ({busy, req0_ready} !== 2'b10) begin
        n_err++; $display("FAIL limit_busy[%0d]: got busy=%b r0=%b want 1 0", i, busy, req0_ready);
      end
      wait_valid(lat);
      n_cmp++;
      if (lat !== 9) begin
        n_err++; $display("FAIL limit_latency[%0d]: got %0d want 9", i, lat);
      end
      n_cmp++;
      if ({out_id, out_bcd} !== {1'b0, exps[i]}) begin
        n_err++; $display("FAIL limit_result[%0d]: got id=%b bcd=%h want id=0 bcd=%h", i, out_id, out_bcd, exps[i]);
      end
      tick();
      n_cmp++;
      if ({out_valid, busy} !== 2'b00) begin
        n_err++; $display("FAIL limit_release[%0d]: got v=%b busy=%b want 0 0", i, out_valid, busy);
      end
    end
  endtask

  task automatic test_tie_alternate();
    int lat, ng, nr, cyc;
    logic [3:0] seq;
    rst_n = 1'b0; #1; tick(); rst_n = 1'b1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_bin = 9'd100;
    req1_valid = 1'b1; req1_bin = 9'd37;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL tie_first_grant: got %b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk); #2;
    req0_valid = 1'b0;
    wait_valid(lat);
    n_cmp++;
    if (lat !== 9 || {out_id, out_bcd} !== {1'b0, 12'h100}) begin
      n_err++; $display("FAIL tie_result0: got lat=%0d id=%b bcd=%h want 9 0 100", lat, out_id, out_bcd);
    end
    tick(); #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL tie_second_grant: got %b%b want 01", req0_ready, req1_ready);
    end
    @(posedge clk); #2;
    req1_valid = 1'b0;
    wait_valid(lat);
    n_cmp++;
    if (lat !== 9 || {out_id, out_bcd} !== {1'b1, 12'h037}) begin
      n_err++; $display("FAIL tie_result1: got lat=%0d id=%b bcd=%h want 9 1 037", lat, out_id, out_bcd);
    end
    tick();
    // Both held continuously: grants must alternate starting with requester 0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0; nr = 0; cyc = 0; seq = '0;
    while (ng < 4 && cyc < 200) begin
      #1;
      if (req0_ready)      begin seq[ng] = 1'b0; ng++; end
      else if (req1_ready) begin seq[ng] = 1'b1; ng++; end
      if (out_valid) begin
        n_cmp++;
        if ({out_id, out_bcd} !== {nr[0], (nr[0] ? 12'h037 : 12'h100)}) begin
          n_err++; $display("FAIL alt_result[%0d]: got id=%b bcd=%h want id=%0d", nr, out_id, out_bcd, nr % 2);
        end
        nr++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if (ng !== 4 || seq !== 4'b1010) begin
      n_err++; $display("FAIL alt_grants: got n=%0d seq(3..0)=%b want 4 1010", ng, seq);
    end
    wait_valid(lat);
    n_cmp++;
    if ({out_valid, out_id, out_bcd} !== {1'b1, 1'b1, 12'h037}) begin
      n_err++; $display("FAIL alt_last_result: got v=%b id=%b bcd=%h want 1 1 037", out_valid, out_id, out_bcd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic bad;
    out_ready = 1'b0;
    tick();
    req1_valid = 1'b1; req1_bin = 9'd42;
    @(posedge clk); #2;
    req1_valid = 1'b0;
    wait_valid(lat);
    n_cmp++;
    if (lat !== 9) begin
      n_err++; $display("FAIL bp_latency: got %0d want 9", lat);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, out_id, out_bcd, req0_ready, req1_ready, busy} !== {1'b1, 1'b1, 12'h042, 1'b0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%b bcd=%h r0=%b r1=%b busy=%b want 1 1 042 0 0 1",
                 i, out_valid, out_id, out_bcd, req0_ready, req1_ready, busy);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++;
    if ({out_valid, busy} !== 2'b00) begin
      n_err++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    logic seen;
    out_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_bin = 9'd123;
    @(posedge clk); #2;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_id, busy, req0_ready, req1_ready, out_bcd} !== 17'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got v=%b id=%b busy=%b r0=%b r1=%b bcd=%h want all zero",
               out_valid, out_id, busy, req0_ready, req1_ready, out_bcd);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
      if (i == 2) rst_n = 1'b1;
      if (i == 2) begin
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
          n_err++; $display("FAIL rst_mid_regrant: got %b%b want 10", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        break;
      end
    end
    n_cmp++;
    if (seen) begin
      n_err++; $display("FAIL rst_mid_no_valid: got out_valid=1 during reset want 0");
    end
    wait_valid(lat);
    n_cmp++;
    if (lat !== 9 || {out_id, out_bcd} !== {1'b0, 12'h123}) begin
      n_err++; $display("FAIL rst_mid_result: got lat=%0d id=%b bcd=%h want 9 0 123", lat, out_id, out_bcd);
    end
    tick();
  endtask

  task automatic test_exhaustive();
    int n0, n1, got, cyc, v;
    logic a0, a1, id;
    int   q_v[$];
    logic q_id[$];
    n0 = 0; n1 = 1; got = 0; cyc = 0;
    tick();
    while (got < 512 && cyc < 30000) begin
      req0_valid = (n0 < 512); req0_bin = 9'(n0 < 512 ? n0 : 0);
      req1_valid = (n1 < 512); req1_bin = 9'(n1 < 512 ? n1 : 0);
      out_ready  = 1'($urandom_range(0, 1));
      #1;
      a0 = req0_ready; a1 = req1_ready;
      if (a0) begin q_v.push_back(n0); q_id.push_back(1'b0); end
      if (a1) begin q_v.push_back(n1); q_id.push_back(1'b1); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q_v.size() == 0) begin
          n_err++; $display("FAIL sweep_duplicate: got extra result id=%b bcd=%h want none", out_id, out_bcd);
        end else begin
          v  = q_v.pop_front();
          id = q_id.pop_front();
          if ({out_id, out_bcd} !== {id, dec_bcd(v)}) begin
            n_err++; $display("FAIL sweep_result[%0d]: got id=%b bcd=%h want id=%b bcd=%h",
                              v, out_id, out_bcd, id, dec_bcd(v));
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (a0) n0 += 2;
      if (a1) n1 += 2;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    n_cmp++;
    if (got !== 512 || q_v.size() != 0) begin
      n_err++; $display("FAIL sweep_count: got %0d results, %0d pending want 512, 0", got, q_v.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_bin = '0;
    req1_valid = 1'b0; req1_bin = '0;
    out_ready  = 1'b1;
    test_reset();
    test_limits();
    test_tie_alternate();
    test_backpressure();
    test_reset_mid_shift();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
